// File: rtl/dr_pipeline_pkg.sv
// Shared datapath defines for the dr_pipeline register chain.
//   DEFAULT_WIDTH : default data width of a datapath register
//   cnt_w()       : width of an occupancy counter able to hold 0..depth
package dr_pipeline_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // A counter for 0..depth needs clog2(depth+1) bits; never less than one.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dr_pipeline_if.sv
// Producer/consumer handshake bundle for dr_pipeline.
//   flush               : synchronous clear of all in-flight entries
//   in_valid/in_data    : producer side, in_ready returned by the pipeline
//   out_valid/out_data  : consumer side, out_ready returned by the consumer
//   count               : registered number of valid stages
// Modports: master = producer/consumer environment, slave = pipeline.
interface dr_pipeline_if #(
    parameter int WIDTH = dr_pipeline_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = 1
) ();
    localparam int CW = dr_pipeline_pkg::cnt_w(DEPTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/dr_stage.sv
// One valid/data register of the dr_pipeline chain.
//   CLK, RST  : clock, synchronous active-high reset
//   flush     : clears the valid bit, leaves data untouched
//   rdy_in    : ready from the downstream stage
//   rdy_out   : ready offered to the upstream stage (empty or draining)
//   vld_in/data_in   : upstream entry
//   vld_out/data_out : this stage's entry
module dr_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             rdy_in,
    output logic             rdy_out,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             vld_out,
    output logic [WIDTH-1:0] data_out
);
    // A stage can take a new entry if it is empty or its entry leaves now.
    assign rdy_out = !vld_out | rdy_in;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_out  <= 1'b0;
            data_out <= RESET_VAL;
        end else if (flush) begin
            vld_out  <= 1'b0;
        end else if (rdy_out) begin
            // Bubbles load too; data is don't-care while vld_out is low.
            vld_out  <= vld_in;
            data_out <= data_in;
        end
    end
endmodule

// File: rtl/dr_pipeline.sv
// DEPTH-stage valid/ready register chain with stall, flush and occupancy.
//   CLK, RST : clock, synchronous active-high reset (beats flush/handshake)
//   bus      : dr_pipeline_if slave (flush, in_*, out_*, count)
// Full throughput: ready ripples combinationally from out_ready to in_ready.
module dr_pipeline
    import dr_pipeline_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          CLK,
    input  logic          RST,
    dr_pipeline_if.slave  bus
);
    localparam int CW = cnt_w(DEPTH);

    if (DEPTH < 1) begin : g_bad_depth
        $error("dr_pipeline: DEPTH must be at least 1");
    end

    // Index 0 is the producer side; stage i drives index i+1.
    logic [DEPTH:0]            vld_pipe;
    logic [DEPTH:0][WIDTH-1:0] dat_pipe;
    logic [DEPTH:0]            rdy;

    assign vld_pipe[0] = bus.in_valid;
    assign dat_pipe[0] = bus.in_data;
    assign rdy[DEPTH]  = bus.out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dr_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .CLK      (CLK),
            .RST      (RST),
            .flush    (bus.flush),
            .rdy_in   (rdy[i+1]),
            .rdy_out  (rdy[i]),
            .vld_in   (vld_pipe[i]),
            .data_in  (dat_pipe[i]),
            .vld_out  (vld_pipe[i+1]),
            .data_out (dat_pipe[i+1])
        );
    end

    // Flush blocks both sides so nothing transfers in the flush cycle.
    assign bus.in_ready  = rdy[0] & !bus.flush;
    assign bus.out_valid = vld_pipe[DEPTH] & !bus.flush;
    assign bus.out_data  = dat_pipe[DEPTH];

    logic          in_xfer, out_xfer;
    logic [CW-1:0] count_q;

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    always_ff @(posedge CLK) begin
        if (RST || bus.flush) count_q <= '0;
        else                  count_q <= count_q + CW'(in_xfer) - CW'(out_xfer);
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_dr_pipeline.sv
// Self-checking bench: a DEPTH=3/WIDTH=32 and a DEPTH=1/WIDTH=8 pipeline
// share one clock and reset. Negedge monitors keep a scoreboard queue per
// instance; directed tasks check registered outputs #1 after each edge.
module tb_dr_pipeline;
    logic CLK;
    logic RST;

    int n_chk  = 0;
    int n_fail = 0;

    dr_pipeline_if #(.WIDTH(32), .DEPTH(3)) ia ();
    dr_pipeline_if #(.WIDTH(8),  .DEPTH(1)) ib ();

    dr_pipeline #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u_a (
        .CLK (CLK), .RST (RST), .bus (ia)
    );
    dr_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h0)) u_b (
        .CLK (CLK), .RST (RST), .bus (ib)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] qa[$];
    logic [7:0]  qb[$];

    // Scoreboards: push on accept, pop/compare on emit, discard on reset/flush.
    always @(negedge CLK) begin
        logic [31:0] ea;
        logic [7:0]  eb;
        if (RST || ia.flush) qa.delete();
        else begin
            if (ia.out_valid && ia.out_ready) begin
                n_chk++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_a_extra: out_data=%h emitted, required no output", ia.out_data);
                end else begin
                    ea = qa.pop_front();
                    if (ia.out_data !== ea) begin
                        n_fail++;
                        $display("FAIL sb_a_data: got %h, required %h", ia.out_data, ea);
                    end
                end
            end
            if (ia.in_valid && ia.in_ready) qa.push_back(ia.in_data);
        end
        if (RST || ib.flush) qb.delete();
        else begin
            if (ib.out_valid && ib.out_ready) begin
                n_chk++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_b_extra: out_data=%h emitted, required no output", ib.out_data);
                end else begin
                    eb = qb.pop_front();
                    if (ib.out_data !== eb) begin
                        n_fail++;
                        $display("FAIL sb_b_data: got %h, required %h", ib.out_data, eb);
                    end
                end
            end
            if (ib.in_valid && ib.in_ready) qb.push_back(ib.in_data);
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        ia.flush = 1'b0; ia.in_valid = 1'b1; ia.in_data = 32'hDEAD_BEEF; ia.out_ready = 1'b1;
        ib.flush = 1'b0; ib.in_valid = 1'b1; ib.in_data = 8'hAD;         ib.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_chk++;
        if (ia.out_valid !== 1'b0 || ia.count !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_hold: out_valid=%b count=%0d, required 0/0", ia.out_valid, ia.count);
        end
        RST = 1'b0; ia.in_valid = 1'b0; ib.in_valid = 1'b0;
        #1;
        n_chk++;
        if (ia.out_valid !== 1'b0 || ia.out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: out_valid=%b out_data=%h, required 0/0", ia.out_valid, ia.out_data);
        end
        n_chk++;
        if (ia.count !== 2'd0 || ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cnt_rdy: count=%0d in_ready=%b, required 0/1", ia.count, ia.in_ready);
        end
        n_chk++;
        if (ib.out_valid !== 1'b0 || ib.out_data !== 8'h0 || ib.count !== 1'b0 || ib.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_b: v=%b d=%h cnt=%0d rdy=%b, required 0/00/0/1",
                     ib.out_valid, ib.out_data, ib.count, ib.in_ready);
        end
    endtask

    task automatic test_stream();
        logic        ev;
        logic [31:0] ed;
        @(posedge CLK); #1;
        ia.out_ready = 1'b1;
        // Words accepted at edges 1..4 appear after edges 3..6.
        for (int k = 0; k < 8; k++) begin
            ia.in_valid = (k < 4);
            ia.in_data  = 32'(k + 1);
            @(posedge CLK); #1;
            ev = (k + 1 >= 3) && (k + 1 <= 6);
            ed = 32'(k - 1);
            n_chk++;
            if (ia.out_valid !== ev || (ev && ia.out_data !== ed)) begin
                n_fail++;
                $display("FAIL stream_c%0d: v=%b d=%h, required v=%b d=%h", k, ia.out_valid, ia.out_data, ev, ed);
            end
        end
        ia.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        ia.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 32'(10 + k);
            @(posedge CLK); #1;
        end
        ia.in_data = 32'd13;
        #1;
        n_chk++;
        if (ia.count !== 2'd3 || ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || ia.out_data !== 32'd10) begin
            n_fail++;
            $display("FAIL bp_full: cnt=%0d rdy=%b v=%b d=%0d, required 3/0/1/10",
                     ia.count, ia.in_ready, ia.out_valid, ia.out_data);
        end
        @(posedge CLK); #1;
        n_chk++;
        if (ia.out_data !== 32'd10 || ia.count !== 2'd3) begin
            n_fail++;
            $display("FAIL bp_stall: d=%0d cnt=%0d, required 10/3", ia.out_data, ia.count);
        end
        ia.out_ready = 1'b1;
        #1;
        n_chk++;
        if (ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_full_thru_rdy: in_ready=%b, required 1", ia.in_ready);
        end
        @(posedge CLK); #1;
        n_chk++;
        if (ia.count !== 2'd3 || ia.out_data !== 32'd11) begin
            n_fail++;
            $display("FAIL bp_release: cnt=%0d d=%0d, required 3/11", ia.count, ia.out_data);
        end
        ia.out_ready = 1'b0; ia.in_valid = 1'b0;
        @(posedge CLK); #1;
        n_chk++;
        if (ia.out_data !== 32'd11 || ia.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold2: v=%b d=%0d, required 1/11", ia.out_valid, ia.out_data);
        end
        ia.out_ready = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        n_chk++;
        if (ia.count !== 2'd0 || ia.out_valid !== 1'b0 || qa.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: cnt=%0d v=%b pending=%0d, required 0/0/0", ia.count, ia.out_valid, qa.size());
        end
    endtask

    task automatic test_flush();
        ia.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 32'(20 + k);
            @(posedge CLK); #1;
        end
        ia.in_valid = 1'b0;
        @(posedge CLK); #1;
        n_chk++;
        if (ia.count !== 2'd2 || ia.out_valid !== 1'b1 || ia.out_data !== 32'd20) begin
            n_fail++;
            $display("FAIL flush_pre: cnt=%0d v=%b d=%0d, required 2/1/20", ia.count, ia.out_valid, ia.out_data);
        end
        ia.in_valid = 1'b1; ia.in_data = 32'd22; ia.out_ready = 1'b1; ia.flush = 1'b1;
        #1;
        n_chk++;
        if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_cycle: in_ready=%b out_valid=%b, required 0/0", ia.in_ready, ia.out_valid);
        end
        @(posedge CLK); #1;
        ia.flush = 1'b0; ia.in_valid = 1'b0;
        #1;
        n_chk++;
        if (ia.count !== 2'd0 || ia.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_after: cnt=%0d v=%b, required 0/0", ia.count, ia.out_valid);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK); #1;
            n_chk++;
            if (ia.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_leak_c%0d: out_valid=%b d=%0d, required 0", k, ia.out_valid, ia.out_data);
            end
        end
    endtask

    task automatic test_reset_stall();
        ia.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 32'(30 + k);
            @(posedge CLK); #1;
        end
        ia.in_valid = 1'b0;
        n_chk++;
        if (ia.count !== 2'd3) begin
            n_fail++;
            $display("FAIL rst_stall_fill: cnt=%0d, required 3", ia.count);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        n_chk++;
        if (ia.out_valid !== 1'b0 || ia.out_data !== 32'h0 || ia.count !== 2'd0 || ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_stall: v=%b d=%h cnt=%0d rdy=%b, required 0/0/0/1",
                     ia.out_valid, ia.out_data, ia.count, ia.in_ready);
        end
        for (int k = 0; k < 2; k++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 32'(40 + k);
            @(posedge CLK); #1;
        end
        ia.in_valid = 1'b0;
        RST = 1'b1; ia.flush = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        n_chk++;
        if (ia.count !== 2'd0 || ia.out_valid !== 1'b0 || ia.out_data !== 32'h0 || ia.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flush: cnt=%0d v=%b d=%h rdy=%b, required 0/0/0/0",
                     ia.count, ia.out_valid, ia.out_data, ia.in_ready);
        end
        ia.flush = 1'b0;
        #1;
        n_chk++;
        if (ia.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_flush_rdy: in_ready=%b, required 1", ia.in_ready);
        end
    endtask

    task automatic test_depth1();
        int   expc = 0;
        logic inx, outx, erdy;
        @(posedge CLK); #1;
        for (int k = 0; k < 40; k++) begin
            ib.in_valid  = 1'b1;
            ib.in_data   = 8'($urandom);
            ib.out_ready = (k % 2 == 0);
            #1;
            erdy = (expc == 0) || ib.out_ready;
            n_chk++;
            if (ib.in_ready !== erdy) begin
                n_fail++;
                $display("FAIL d1_rdy_c%0d: in_ready=%b, required %b", k, ib.in_ready, erdy);
            end
            inx  = ib.in_valid && ib.in_ready;
            outx = ib.out_valid && ib.out_ready;
            expc = expc + int'(inx) - int'(outx);
            @(posedge CLK); #1;
            n_chk++;
            if (ib.count !== 1'(expc)) begin
                n_fail++;
                $display("FAIL d1_cnt_c%0d: count=%0d, required %0d", k, ib.count, expc);
            end
        end
        ib.in_valid = 1'b0; ib.out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        n_chk++;
        if (ib.count !== 1'b0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL d1_drain: cnt=%0d pending=%0d, required 0/0", ib.count, qb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_stall();
        test_depth1();
        @(posedge CLK); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
